// File: rtl/problem_sequencer_pkg.sv
// Shared types and constants for the column scheduler.
// Row/column widths, store sizing and sequencer states.
package problem_sequencer_pkg;

   localparam int DEF_ROW_WIDTH      = 3;
   localparam int DEF_COL_WIDTH      = 10;
   localparam int MAX_ARGUMENT_COUNT = 1 << DEF_ROW_WIDTH;
   localparam int ARG_RANKS          = 1000;

   typedef logic [DEF_ROW_WIDTH-1:0] arg_row_t;
   typedef logic [DEF_COL_WIDTH-1:0] arg_col_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      READ    = 2'd1,
      ISSUE   = 2'd2,
      DONE    = 2'd3
   } seq_state_t;

endpackage

// File: rtl/problem_sequencer_op_store.sv
// Operator store: 1-bit wide, synchronous write, asynchronous read.
// Maps onto distributed RAM.
module problem_sequencer_op_store
   import problem_sequencer_pkg::*;
#(
   parameter int DEPTH = 1000,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic          wdata,
   input  logic [AW-1:0] raddr,
   output logic          rdata
);

   logic mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/problem_sequencer.sv
// Column scheduler: records operators, then issues one problem per
// column to the arithmetic unit under a valid/ready handshake.
module problem_sequencer
   import problem_sequencer_pkg::*;
#(
   parameter int ARG_ROW_WIDTH = 3,
   parameter int ARG_COL_WIDTH = 10,
   parameter int MAX_PROBLEMS  = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     op_valid,
   input  logic                     op_mult_add,
   input  logic [ARG_ROW_WIDTH-1:0] op_row_count,
   input  logic                     end_of_input,
   output logic [ARG_COL_WIDTH-1:0] rd_col,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic                     issue_mult_add,
   output logic [ARG_ROW_WIDTH-1:0] issue_row_count,
   output logic                     done,
   output logic                     op_overflow,
   output logic                     late_op
);

   localparam int CW = ARG_COL_WIDTH;
   localparam logic [CW:0] MAX_CNT = (CW+1)'(MAX_PROBLEMS);
   localparam logic [CW:0] ONE_CNT = (CW+1)'(1);

   localparam logic [1:0] S_COLLECT = COLLECT;
   localparam logic [1:0] S_READ    = READ;
   localparam logic [1:0] S_ISSUE   = ISSUE;
   localparam logic [1:0] S_DONE    = DONE;

   logic [1:0]               state;
   logic [CW:0]              op_count;
   logic [CW-1:0]            col;
   logic [ARG_ROW_WIDTH-1:0] row_count;

   logic        room;
   logic        accept;
   logic        last_col;
   logic        store_q;
   logic [CW:0] total;

   assign room     = op_count < MAX_CNT;
   assign accept   = (state == S_COLLECT) && op_valid && room;
   // an operator accepted alongside end_of_input still counts
   assign total    = op_count + {{CW{1'b0}}, accept};
   assign last_col = {1'b0, col} == (op_count - ONE_CNT);

   problem_sequencer_op_store #(
      .DEPTH (MAX_PROBLEMS),
      .AW    (CW)
   ) u_op_store (
      .clk   (clk),
      .we    (accept),
      .waddr (op_count[CW-1:0]),
      .wdata (op_mult_add),
      .raddr (col),
      .rdata (store_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_COLLECT;
         op_count    <= '0;
         col         <= '0;
         row_count   <= '0;
         op_overflow <= 1'b0;
         late_op     <= 1'b0;
      end else begin
         if (op_valid && state != S_COLLECT) late_op <= 1'b1;
         unique case (state)
            S_COLLECT: begin
               if (accept) begin
                  op_count <= op_count + ONE_CNT;
                  if (op_count == '0) row_count <= op_row_count;
               end
               if (op_valid && !room) op_overflow <= 1'b1;
               if (end_of_input) begin
                  col   <= '0;
                  state <= (total == '0) ? S_DONE : S_READ;
               end
            end
            S_READ: state <= S_ISSUE;
            S_ISSUE: begin
               if (issue_ready) begin
                  if (last_col) begin
                     state <= S_DONE;
                  end else begin
                     col   <= col + CW'(1);
                     state <= S_READ;
                  end
               end
            end
            S_DONE: ;
            default: state <= S_COLLECT;
         endcase
      end
   end

   assign rd_col          = col;
   assign issue_valid     = state == S_ISSUE;
   assign issue_mult_add  = issue_valid & store_q;
   assign issue_row_count = issue_valid ? row_count : '0;
   assign done            = state == S_DONE;

endmodule

// File: tb/tb_problem_sequencer.sv
// Scoreboard bench for problem_sequencer: directed operator streams,
// expected issues queued at stimulus time, popped by a monitor.
module tb_problem_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid;
   logic       op_mult_add;
   logic [2:0] op_row_count;
   logic       end_of_input;
   logic [9:0] rd_col;
   logic       issue_valid;
   logic       issue_ready;
   logic       issue_mult_add;
   logic [2:0] issue_row_count;
   logic       done;
   logic       op_overflow;
   logic       late_op;

   problem_sequencer #(
      .ARG_ROW_WIDTH (3),
      .ARG_COL_WIDTH (10),
      .MAX_PROBLEMS  (1000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .op_valid        (op_valid),
      .op_mult_add     (op_mult_add),
      .op_row_count    (op_row_count),
      .end_of_input    (end_of_input),
      .rd_col          (rd_col),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .issue_mult_add  (issue_mult_add),
      .issue_row_count (issue_row_count),
      .done            (done),
      .op_overflow     (op_overflow),
      .late_op         (late_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      int col;
      bit m;
      int rows;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   fails    = 0;
   int   accepts  = 0;
   int   ncol     = 0;
   int   exp_rows = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
         accepts++;
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_issue: got col %0d expected none",
                     rd_col);
         end else begin
            e = sb.pop_front();
            check("issue_col", 32'(rd_col), e.col);
            check("issue_mult", 32'(issue_mult_add), 32'(e.m));
            check("issue_rows", 32'(issue_row_count), e.rows);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit m, input int rows,
                       input bit eoi = 1'b0, input bit ex = 1'b1);
      op_valid     = 1'b1;
      op_mult_add  = m;
      op_row_count = 3'(rows);
      end_of_input = eoi;
      if (ex) begin
         sb.push_back('{ncol, m, exp_rows});
         ncol++;
      end
      step();
      op_valid     = 1'b0;
      end_of_input = 1'b0;
   endtask

   task automatic eoi();
      end_of_input = 1'b1;
      step();
      end_of_input = 1'b0;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      op_valid     = 1'b0;
      end_of_input = 1'b0;
      issue_ready  = 1'b0;
      sb.delete();
      step();
      rst     = 1'b0;
      accepts = 0;
      ncol    = 0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("done_reached", 32'(done), 1);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      op_valid     = 1'b0;
      op_mult_add  = 1'b0;
      op_row_count = 3'd0;
      end_of_input = 1'b0;
      issue_ready  = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_valid", 32'(issue_valid), 0);
      check("rst_rd_col", 32'(rd_col), 0);
      check("rst_done", 32'(done), 0);
      check("rst_mult", 32'(issue_mult_add), 0);
      check("rst_rows", 32'(issue_row_count), 0);
      check("rst_ovf", 32'(op_overflow), 0);
      check("rst_late", 32'(late_op), 0);

      // basic: rows sampled on the first operator only
      exp_rows    = 4;
      issue_ready = 1'b1;
      send(1, 4);
      send(0, 7);
      send(1, 7);
      eoi();
      for (int i = 0; i < 3; i++) begin
         check("read_gap", 32'(issue_valid), 0);
         check("read_col", 32'(rd_col), i);
         step();
         check("issue_on", 32'(issue_valid), 1);
         step();
      end
      check("basic_done", 32'(done), 1);
      check("basic_valid_off", 32'(issue_valid), 0);
      check("basic_accepts", accepts, 3);

      // backpressure on col 1
      do_reset();
      exp_rows = 3;
      send(1, 3);
      send(0, 3);
      send(1, 3);
      issue_ready = 1'b1;
      eoi();
      step();
      step();
      issue_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(issue_valid), 1);
         check("bp_col", 32'(rd_col), 1);
         check("bp_mult", 32'(issue_mult_add), 0);
         step();
      end
      issue_ready = 1'b1;
      wait_done(20);
      check("bp_accepts", accepts, 3);

      // empty input
      do_reset();
      issue_ready = 1'b1;
      eoi();
      check("empty_done", 32'(done), 1);
      check("empty_valid", 32'(issue_valid), 0);
      step();
      step();
      check("empty_accepts", accepts, 0);

      // last operator coincides with end_of_input
      do_reset();
      exp_rows    = 5;
      issue_ready = 1'b1;
      send(1, 5);
      send(0, 5, 1'b1);
      wait_done(20);
      check("same_accepts", accepts, 2);
      check("same_late", 32'(late_op), 0);

      // overflow, then a late operator during issue
      do_reset();
      exp_rows    = 2;
      issue_ready = 1'b1;
      for (int i = 0; i < 1001; i++) begin
         if (i == 1000) check("ovf_before", 32'(op_overflow), 0);
         send((i % 3) == 0, 2, 1'b0, i < 1000);
      end
      check("ovf_flag", 32'(op_overflow), 1);
      check("ovf_late", 32'(late_op), 0);
      eoi();
      step();
      step();
      step();
      send(1, 6, 1'b0, 1'b0);
      check("late_flag", 32'(late_op), 1);
      wait_done(2100);
      check("ovf_accepts", accepts, 1000);
      check("ovf_sticky", 32'(op_overflow), 1);

      // reset while issuing col 3
      do_reset();
      exp_rows = 1;
      send(1, 1);
      send(0, 1);
      send(1, 1);
      send(0, 1);
      send(1, 1);
      issue_ready = 1'b1;
      eoi();
      n = 0;
      while (!(issue_valid === 1'b1 && rd_col == 10'd3) && n < 50) begin
         step();
         n++;
      end
      issue_ready = 1'b0;
      check("mid_reached", 32'(n < 50), 1);
      sb.delete();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_valid", 32'(issue_valid), 0);
      check("mid_rd_col", 32'(rd_col), 0);
      check("mid_done", 32'(done), 0);
      check("mid_state", 32'(dut.state), 0);
      accepts  = 0;
      ncol     = 0;
      exp_rows = 6;
      send(0, 6);
      send(1, 6);
      issue_ready = 1'b1;
      eoi();
      wait_done(20);
      check("mid_accepts", accepts, 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
